regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised register file for the RISC-V core datapath. Generalised in width, depth and read-port count.
- Adds an optional hardwired-zero x0 and optional write-to-read bypass.
- Adds a per-register pending scoreboard that the decode stage uses to detect RAW hazards.
- Sits between decode (read/issue side) and writeback (write side), and replaces the fixed 2-read/1-write 32x32 file.

Parameters:
- XLEN, 32, data width of each register in bits.
- NREG, 32, number of registers; power of two, at least 2. Localparam AW = $clog2(NREG).
- NREAD, 2, number of combinational read ports, 1 to 4.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- regwrite  in  1  writeback write enable.
- writeReg  in  AW  writeback destination index.
- writeData  in  XLEN  writeback data.
- readAddr  in  NREAD*AW  read indices, packed; port i occupies [i*AW +: AW].
- readData  out  NREAD*XLEN  read data, packed; port i occupies [i*XLEN +: XLEN].
- issue  in  1  decode issues an instruction with a destination register.
- issueReg  in  AW  destination index of the issued instruction.
- busy  out  NREAD  busy[i]=1 means readData port i is not yet valid (producer outstanding).
- anyPending  out  1  OR of all pending bits.

Behaviour:
- Reset, while rst=1, asynchronous:
  - All NREG entries go to 0 and all pending bits go to 0.
  - readData reads 0 and busy=0, anyPending=0.
  - Reset mid-operation discards any write or issue in that cycle.
- Write: on posedge clk, if regwrite, RF[writeReg] <= writeData. Ignored when ZERO_REG=1 and writeReg=0.
- Read: combinational, zero-cycle latency. For each port i with address a:
  - ZERO_REG=1 and a=0 -> 0.
  - Otherwise, BYPASS=1 and regwrite and writeReg==a (and the write is not suppressed) -> writeData.
  - Otherwise -> RF[a].
  - Several ports may read the same address; each resolves independently.
- Scoreboard, one pending bit per register, updated on posedge clk:
  - issue and issueReg=r (r≠0 when ZERO_REG=1) sets pending[r].
  - An effective regwrite to r clears pending[r].
  - If issue and write target the same r in the same cycle, set wins: the new producer is outstanding.
  - Issue or write to x0 has no effect when ZERO_REG=1.
  - Issuing to an already pending register leaves it pending. Single-bit tracking; decode must stall a WAW via busy on rd.
- busy[i], combinational:
  - pending[a] AND NOT (BYPASS and regwrite and writeReg==a).
  - With BYPASS=0, busy[i] = pending[a] regardless of the same-cycle write.
  - Always 0 for a=0 when ZERO_REG=1.
- anyPending is combinational from the pending register state (post-reset, pre-edge).
- Widths:
  - Addresses are AW bits and are all in range because NREG is a power of two.
  - writeData is stored with no sign or zero extension.
- No combinational path from issue or issueReg to any output.

Test Plan:
- Reset with rst asserted asynchronously between clock edges -> all readData ports immediately 0, busy=0, anyPending=0. Leave the default parameters for this test.
- Write and read-after-write:
  - Write 0xDEADBEEF to x5, then 0x12345678 to x31.
  - Next cycle, read ports {x5, x31} -> readData = {0xDEADBEEF, 0x12345678}.
  - Write 0xFFFFFFFF to x0 -> reading x0 returns 0.
- Bypass:
  - With x7=0x1, in the same cycle regwrite x7 <= 0xA5A5A5A5 while both ports read x7 -> both readData = 0xA5A5A5A5 in that cycle.
  - Repeat with BYPASS=0 -> both return 0x1 that cycle and 0xA5A5A5A5 the next.
- Scoreboard:
  - issue x3 -> next cycle busy=1 for a port reading x3 and anyPending=1.
  - Two cycles later regwrite x3 <= 0x55 -> busy=0 in that same cycle with readData=0x55.
  - Following cycle anyPending=0.
- Simultaneous issue and write:
  - pending x9; in one cycle regwrite x9 <= 0x10 and issue x9 -> after the edge RF[x9]=0x10 and pending[x9] is still 1 (busy=1).
  - issue x0 -> anyPending stays 0.
- Parameter sweep: XLEN=64, NREG=16, NREAD=4, ZERO_REG=0.
  - Write 0x0123456789ABCDEF to r0 and read it on all 4 ports -> all return the value.
  - issue r0 -> busy=4'b1111.
  - Assert rst mid-sequence -> everything reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read register file with optional x0, write bypass and pending scoreboard
module regfile_mp #(
   parameter  int XLEN     = 32,
   parameter  int NREG     = 32,
   parameter  int NREAD    = 2,
   parameter  int BYPASS   = 1,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  regwrite,
   input  logic [AW-1:0]         writeReg,
   input  logic [XLEN-1:0]       writeData,
   input  logic [NREAD*AW-1:0]   readAddr,
   output logic [NREAD*XLEN-1:0] readData,
   input  logic                  issue,
   input  logic [AW-1:0]         issueReg,
   output logic [NREAD-1:0]      busy,
   output logic                  anyPending
);
   logic [XLEN-1:0] rf [NREG];
   logic [NREG-1:0] pend, pend_n;
   logic            wr_en, is_en;
   assign wr_en = regwrite && !rst && !(ZERO_REG != 0 && writeReg == '0);
   assign is_en = issue && !(ZERO_REG != 0 && issueReg == '0);
   assign anyPending = |pend;
   // next scoreboard: the issue is applied after the write clear so a new producer stays outstanding
   always_comb begin
      pend_n = pend;
      if (wr_en) pend_n[writeReg] = 1'b0;
      if (is_en) pend_n[issueReg] = 1'b1;
   end
   // register storage and pending bits, both cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NREG; k++) rf[k] <= '0;
         pend <= '0;
      end else begin
         if (wr_en) rf[writeReg] <= writeData;
         pend <= pend_n;
      end
   end
   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          z, b;
      assign a = readAddr[i*AW +: AW];
      assign z = ZERO_REG != 0 && a == '0;
      assign b = BYPASS != 0 && wr_en && writeReg == a;
      assign readData[i*XLEN +: XLEN] = z ? '0 : b ? writeData : rf[a];
      assign busy[i] = !z && !b && pend[a];
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench checking three regfile_mp configurations against an array model
module tb_regfile_mp;
   logic         clk = 0;
   logic         rst = 1;
   logic         rw = 0, iss = 0;
   logic [4:0]   wr = 0, ir = 0;
   logic [31:0]  wd = 0;
   logic [9:0]   ra = 0;
   logic [63:0]  rd0, rd1;
   logic [1:0]   busy0, busy1;
   logic         ap0, ap1;
   logic         rw2 = 0, iss2 = 0;
   logic [3:0]   wr2 = 0, ir2 = 0;
   logic [63:0]  wd2 = 0;
   logic [15:0]  ra2 = 0;
   logic [255:0] rd2;
   logic [3:0]   busy2;
   logic         ap2;
   int checks = 0, failures = 0;
   logic [63:0] mem [3][32];
   bit          pend [3][32];
   int          a_s [4];
   logic [63:0] r_s [4];

   always #5 clk = ~clk;

   regfile_mp u0 (.clk(clk), .rst(rst), .regwrite(rw), .writeReg(wr), .writeData(wd), .readAddr(ra),
      .readData(rd0), .issue(iss), .issueReg(ir), .busy(busy0), .anyPending(ap0));
   regfile_mp #(.BYPASS(0)) u1 (.clk(clk), .rst(rst), .regwrite(rw), .writeReg(wr), .writeData(wd),
      .readAddr(ra), .readData(rd1), .issue(iss), .issueReg(ir), .busy(busy1), .anyPending(ap1));
   regfile_mp #(.XLEN(64), .NREG(16), .NREAD(4), .ZERO_REG(0)) u2 (.clk(clk), .rst(rst), .regwrite(rw2),
      .writeReg(wr2), .writeData(wd2), .readAddr(ra2), .readData(rd2), .issue(iss2), .issueReg(ir2),
      .busy(busy2), .anyPending(ap2));

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // model: what every port must show given the register/pending contents and this cycle's inputs
   task automatic model_step(input int d, input logic w, input int wa, input logic [63:0] wdat,
                             input logic is, input int ia, input logic [3:0] bz, input logic ap);
      int nr = d == 2 ? 4 : 2;
      bit byp = d != 1;
      bit zr = d != 2;
      logic [63:0] mask = d == 2 ? '1 : 64'hFFFF_FFFF;
      bit we, ie, anyp, zero, fwd;
      logic [63:0] er;
      if (rst) begin
         chk($sformatf("d%0d_ap_rst", d), ap, 0);
         for (int i = 0; i < nr; i++) begin
            chk($sformatf("d%0d_rd%0d_rst", d, i), r_s[i], 0);
            chk($sformatf("d%0d_busy%0d_rst", d, i), bz[i], 0);
         end
         for (int r = 0; r < 32; r++) begin
            mem[d][r] = 0;
            pend[d][r] = 0;
         end
         return;
      end
      we = w && !(zr && wa == 0);
      ie = is && !(zr && ia == 0);
      anyp = 0;
      for (int r = 0; r < 32; r++) anyp |= pend[d][r];
      chk($sformatf("d%0d_ap", d), ap, anyp);
      for (int i = 0; i < nr; i++) begin
         zero = zr && a_s[i] == 0;
         fwd = byp && we && wa == a_s[i];
         er = zero ? 64'd0 : fwd ? (wdat & mask) : mem[d][a_s[i]];
         chk($sformatf("d%0d_rd%0d", d, i), r_s[i], er);
         chk($sformatf("d%0d_busy%0d", d, i), bz[i], !zero && !fwd && pend[d][a_s[i]]);
      end
      if (we) begin
         mem[d][wa] = wdat & mask;
         pend[d][wa] = 0;
      end
      if (ie) pend[d][ia] = 1;
   endtask

   // compare process: inputs are stable at the falling edge and apply at the next rising edge
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         a_s[i] = int'(ra[i*5 +: 5]);
         r_s[i] = {32'd0, rd0[i*32 +: 32]};
      end
      model_step(0, rw, int'(wr), {32'd0, wd}, iss, int'(ir), {2'b00, busy0}, ap0);
      for (int i = 0; i < 2; i++) r_s[i] = {32'd0, rd1[i*32 +: 32]};
      model_step(1, rw, int'(wr), {32'd0, wd}, iss, int'(ir), {2'b00, busy1}, ap1);
      for (int i = 0; i < 4; i++) begin
         a_s[i] = int'(ra2[i*4 +: 4]);
         r_s[i] = rd2[i*64 +: 64];
      end
      model_step(2, rw2, int'(wr2), wd2, iss2, int'(ir2), busy2, ap2);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      rst = 0;
      ra = {5'd0, 5'd5};
      rw = 1; wr = 5; wd = 32'hDEADBEEF; iss = 1; ir = 4;
      tick();
      rw = 0; iss = 0;
      #1 chk("pre_rst_rd", rd0[31:0], 32'hDEADBEEF);
      chk("pre_rst_ap", ap0, 1);
      #1 rst = 1;
      #1 chk("async_rst_rd", rd0, 0);
      chk("async_rst_busy", busy0, 0);
      chk("async_rst_ap", ap0, 0);
      tick();
      rst = 0;
      rw = 1; wr = 5; wd = 32'hDEADBEEF;
      tick();
      wr = 31; wd = 32'h12345678;
      tick();
      rw = 0; ra = {5'd31, 5'd5};
      #1 chk("raw_rd", rd0, {32'h12345678, 32'hDEADBEEF});
      rw = 1; wr = 0; wd = 32'hFFFFFFFF; ra = 0;
      #1 chk("x0_write_same", rd0, 0);
      tick();
      rw = 0;
      #1 chk("x0_write_after", rd0, 0);
      rw = 1; wr = 7; wd = 32'h1;
      tick();
      wd = 32'hA5A5A5A5; ra = {5'd7, 5'd7};
      #1 chk("bypass_on", rd0, {2{32'hA5A5A5A5}});
      chk("bypass_off", rd1, {2{32'h1}});
      tick();
      rw = 0;
      #1 chk("bypass_off_next", rd1, {2{32'hA5A5A5A5}});
      iss = 1; ir = 3; ra = {5'd3, 5'd3};
      tick();
      iss = 0;
      #1 chk("sb_busy", busy0, 2'b11);
      chk("sb_ap", ap0, 1);
      tick();
      tick();
      rw = 1; wr = 3; wd = 32'h55;
      #1 chk("sb_clear_busy", busy0, 2'b00);
      chk("sb_clear_rd", rd0, {2{32'h55}});
      chk("sb_nobyp_busy", busy1, 2'b11);
      tick();
      rw = 0;
      #1 chk("sb_ap_after", ap0, 0);
      iss = 1; ir = 9;
      tick();
      rw = 1; wr = 9; wd = 32'h10; ra = {5'd9, 5'd9};
      tick();
      rw = 0; iss = 0;
      #1 chk("set_wins_rd", rd0, {2{32'h10}});
      chk("set_wins_busy", busy0, 2'b11);
      rw = 1;
      tick();
      rw = 0; iss = 1; ir = 0;
      tick();
      iss = 0;
      #1 chk("issue_x0_ap", ap0, 0);
      rw2 = 1; wr2 = 0; wd2 = 64'h0123456789ABCDEF;
      tick();
      rw2 = 0; ra2 = 0;
      #1 chk("wide_rd", rd2, {4{64'h0123456789ABCDEF}});
      iss2 = 1; ir2 = 0;
      tick();
      iss2 = 0;
      #1 chk("wide_busy", busy2, 4'b1111);
      #1 rst = 1;
      #1 chk("wide_rst_rd", rd2, 0);
      chk("wide_rst_busy", busy2, 0);
      chk("wide_rst_ap", ap2, 0);
      tick();
      rst = 0;
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
